// File: rtl/inst_fetch.sv
// Instruction fetch: PC generation, registered imem request, in-order (pc, inst) FIFO with redirect squash.
// Accept-to-if_valid is memory latency + 1; issue is throttled so stalls never overflow the FIFO.

module inst_fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_dat_o,
  output logic [CW-1:0] cnt_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      assert (!(do_push && !do_pop && cnt_q == CW'(DEPTH)));
      assert (!(do_pop && cnt_q == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (rst && do_push) mem_q[wr_q] <= push_dat_i;
  end

  assign head_dat_o = mem_q[rd_q];
  assign cnt_o      = cnt_q;

endmodule

module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  localparam int         CW       = $clog2(DEPTH + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_ent_t;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_vld_q, req_vld_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] outst_cnt, fifo_cnt;
  logic [CW-1:0] outst_nxt, fifo_nxt;
  logic [31:0]   inflight_pc;
  fetch_ent_t    head_ent, push_ent;
  logic          accept, resp_keep, resp_drop, pop;
  logic          unused_tgt_lsb;

  assign accept    = req_vld_q & imem_req_ready;
  assign resp_keep = imem_resp_valid & (discard_q == '0);
  assign resp_drop = imem_resp_valid & (discard_q != '0);
  assign pop       = if_valid & ~stall_i;
  assign push_ent  = '{pc: inflight_pc, inst: imem_resp_data};
  assign unused_tgt_lsb = ^branch_target_i[1:0];

  // Outstanding count is simply the occupancy of the in-flight pc queue.
  inst_fetch_fifo #(.W(32), .DEPTH(DEPTH)) u_inflight (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (1'b0),
    .push_i     (accept),
    .push_dat_i (addr_q),
    .pop_i      (imem_resp_valid),
    .head_dat_o (inflight_pc),
    .cnt_o      (outst_cnt)
  );

  inst_fetch_fifo #(.W($bits(fetch_ent_t)), .DEPTH(DEPTH)) u_out (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (branch_flag_i),
    .push_i     (resp_keep),
    .push_dat_i (push_ent),
    .pop_i      (pop),
    .head_dat_o (head_ent),
    .cnt_o      (fifo_cnt)
  );

  assign outst_nxt = outst_cnt + CW'(accept) - CW'(imem_resp_valid);
  assign fifo_nxt  = branch_flag_i ? '0 : fifo_cnt + CW'(resp_keep) - CW'(pop);

  // A new request is raised only when a slot is guaranteed for its response,
  // so a held request can wait any number of stalled cycles without overflow.
  always_comb begin
    pc_d      = accept ? pc_q + 32'd4 : pc_q;
    addr_d    = addr_q;
    req_vld_d = req_vld_q & ~accept;
    discard_d = discard_q - CW'(resp_drop);
    if (branch_flag_i) begin
      pc_d      = {branch_target_i[31:2], 2'b00};
      req_vld_d = 1'b0;
      discard_d = outst_nxt;
    end else if (!req_vld_d && (int'(outst_nxt) + int'(fifo_nxt) < DEPTH)) begin
      req_vld_d = 1'b1;
      addr_d    = pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      addr_q    <= '0;
      req_vld_q <= 1'b0;
      discard_q <= '0;
    end else begin
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      req_vld_q <= req_vld_d;
      discard_q <= discard_d;
      assert (discard_q <= outst_cnt);
      assert (!req_vld_q || (int'(outst_cnt) + int'(fifo_cnt) < DEPTH));
    end
  end

  assign imem_req_valid = req_vld_q;
  assign imem_req_addr  = addr_q;
  assign if_valid       = (fifo_cnt != '0);
  assign if_pc          = if_valid ? head_ent.pc   : 32'h0;
  assign if_inst        = if_valid ? head_ent.inst : 32'h0;

endmodule
